rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-back arbiter and hazard scoreboard for the vector register file (15 × 6-lane × 8-bit entries; entry 0 is the scalar bank RS1–RS6). It shares the file's single write port between the ALU result path and the memory load path, and registers the winning write for one cycle before it reaches the file. It also tracks destinations issued but not yet written, and raises `stall` to the decode stage on RAW/WAW hazards. The stack-pointer write port (WE1) bypasses this block.

## Interface
Parameters:
- `NREG`, 15, register-file entries (index 0 = scalar bank)
- `LANES`, 6, lanes per vector
- `W`, 8, lane width in bits

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `alu_valid` / `alu_ready`  in / out  1  ALU write-back handshake
- `alu_dst`  in  4  destination entry
- `alu_data`  in  LANES×W  result vector
- `mem_valid` / `mem_ready`  in / out  1  load write-back handshake
- `mem_dst`  in  4  destination entry, or scalar lane 0–5 when `mem_scalar`=1
- `mem_scalar`  in  1  scalar load; writes lane 0 of `mem_data` into `rf[0][mem_dst]`
- `mem_data`  in  LANES×W  load data
- `iss_valid`  in  1  decode issues an instruction with destination `iss_dst`
- `iss_dst`  in  4  destination to reserve
- `iss_scalar`  in  1  `iss_dst` is a scalar lane
- `chk_a1`, `chk_a2`  in  4  source indices of the instruction in decode
- `chk_sflag`  in  1  the instruction reads the whole scalar bank as operand 2
- `stall`  out  1  hazard present; combinational
- `rf_we`, `rf_sflag`, `rf_ldflag`  out  1  drive WE3 / SFlag / LDFlag
- `rf_a3`  out  4  drives A3
- `rf_wd`  out  LANES×W  drives WD3
- `pend`  out  NREG+LANES  pending bits: vector entries 1–14, then scalar lanes 0–5
- `err`  out  1  sticky: an illegal destination was accepted

## Operation
- Handshake: a transfer occurs when `valid`&`ready` are both high. `ready` is the grant and is combinational from both valids and the round-robin pointer.
- Arbitration:
  - A single valid requester is granted in the same cycle.
  - When both are valid, the requester not granted most recently wins.
  - After reset, ALU has priority.
- The write stage registers the granted `dst`/`data`/`scalar` and drives `rf_*` in the following cycle.
  - ALU write: `rf_sflag`=`rf_ldflag`=0.
  - Scalar load: both flags 1.
  - Vector load: `rf_ldflag`=1, `rf_sflag`=0.
- Illegal destinations:
  - Covered: `dst`=0 or 15 for a vector write; `dst`>5 for a scalar write.
  - Behaviour: the request is still accepted, `rf_we` stays 0, and `err` sets until reset.
- Scoreboard, set: `iss_valid`&!`stall` sets the pending bit for `iss_dst`. `iss_valid` while `stall`=1 is ignored.
- Scoreboard, clear: the pending bit clears on the same edge the registered write lands (`rf_we`=1).
- Scoreboard, simultaneous set and clear of the same bit: set wins.
- Stall condition: `stall` = pend[`chk_a1`] | (`chk_sflag` ? any scalar-lane pend : pend[`chk_a2`]) | pend[`iss_dst`]. The last term is the WAW check.
- Index 0 as a vector source or destination checks all scalar-lane bits.

## Timing
- Grant at edge t; `rf_we` high during cycle t+1; the file updates at edge t+2. The pending bit clears at the same edge t+2.
- `stall` for a dependent source drops in cycle t+2. Read-after-write through the file is then valid, because file reads are combinational.
- Throughput: one write per cycle. A losing requester waits exactly one cycle if the other requester does not reassert.
- Reset values: `rf_we`, `rf_sflag`, `rf_ldflag`, `rf_a3`, `rf_wd`, `pend`, `err`, `stall` all 0. Both `ready` outputs are 0 while `rst`=1.
- Reset mid-operation: an in-flight registered write is dropped, so `rf_we`=0 in the cycle after reset. Pending bits and the round-robin pointer are cleared.

## Structure
- Shared package `vec_pkg`:
  - `LANES`, `W`, `NREG`
  - `vec_t` (`logic [LANES-1:0][W-1:0]`)
  - `wb_req_t` (dst, data, scalar)
  - `SCALAR_IDX`=0, `INVALID_IDX`=15
- Sub-module `rr_arb2`: a two-input round-robin arbiter holding the last-grant pointer flop.
- The write register and the scoreboard stay in the top level.

## Test plan
- ALU only, `alu_dst`=3, data 01..06 → `alu_ready`=1 in the same cycle; next cycle `rf_we`=1, `rf_a3`=3, `rf_wd`=06 05 04 03 02 01, flags 0.
- ALU and MEM both valid for 3 cycles after reset → grants ALU, MEM, ALU; the `rf_we` sequence mirrors this one cycle later.
- Scalar load: `mem_scalar`=1, `mem_dst`=4, lane0=0xAB → `rf_sflag`=`rf_ldflag`=1, `rf_a3`=4; pend bit for scalar lane 4 clears on that edge.
- Issue `iss_dst`=7, then `chk_a1`=7 → `stall`=1 until two cycles after the ALU write to 7 is granted; a second issue to 7 during that time is ignored.
- Issue to 9 and grant a write to 9 in the same cycle → pend[9] remains 1.
- MEM write with `mem_dst`=15 → accepted, `rf_we`=0, `err`=1 until `rst`; asserting `rst` during a pending write → `rf_we`=0 and `pend`=0 next cycle.

Source files
------------

// File: rtl/vec_pkg.sv
// ---------------------------------------------------------------------------
// vec_pkg
// Shared definitions for the vector register file write-back path.
//   LANES / W / NREG : vector geometry (6 lanes x 8 bits, 15 entries)
//   vec_t            : one packed vector value
//   wb_req_t         : one write-back request (destination, data, scalar flag)
//   SCALAR_IDX       : entry 0, the scalar bank RS1-RS6
//   INVALID_IDX      : entry 15, which does not exist in the file
//   dst_legal()      : true when a destination can actually be written
// ---------------------------------------------------------------------------
package vec_pkg;

  localparam int LANES = 6;
  localparam int W     = 8;
  localparam int NREG  = 15;

  localparam logic [3:0] SCALAR_IDX  = 4'd0;
  localparam logic [3:0] INVALID_IDX = 4'd15;

  typedef logic [LANES-1:0][W-1:0] vec_t;

  typedef struct packed {
    logic [3:0] dst;
    vec_t       data;
    logic       scalar;
  } wb_req_t;

  // A scalar write names one lane of the scalar bank; a vector write must
  // avoid the scalar bank itself and the non-existent entry 15.
  function automatic logic dst_legal(input logic [3:0] dst, input logic scalar);
    if (scalar) return dst < 4'(LANES);
    return (dst != SCALAR_IDX) && (dst != INVALID_IDX);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter. Grants are combinational from the requests
// and a one-bit priority pointer; when both inputs request, the one that was
// not granted most recently wins. Input 0 has priority after reset.
//   clk, rst   : clock, synchronous active-high reset (grants forced low)
//   req0, req1 : requests
//   gnt0, gnt1 : one-hot (or zero) grants
// ---------------------------------------------------------------------------
module rr_arb2
  import vec_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  // prio1 = 1 means input 1 wins a tie, i.e. input 0 was granted last.
  logic prio1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0 && req1) begin
        gnt1 = prio1;
        gnt0 = !prio1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Every grant, contested or not, hands tie priority to the other side.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio1 <= 1'b0;
    end else if (gnt0) begin
      prio1 <= 1'b1;
    end else if (gnt1) begin
      prio1 <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
// Shares the register file write port (WE3/A3/WD3) between the ALU result
// path and the memory load path, registers the winning write for one cycle,
// and keeps a scoreboard of issued-but-unwritten destinations so decode can
// stall on RAW/WAW hazards.
//   clk, rst                     : clock, synchronous active-high reset
//   alu_valid/ready/dst/data     : ALU write-back handshake
//   mem_valid/ready/dst/scalar/data : load write-back handshake
//   iss_valid/dst/scalar         : destination reservation from decode
//   chk_a1, chk_a2, chk_sflag    : sources of the instruction in decode
//   stall                        : combinational hazard flag to decode
//   rf_we/sflag/ldflag/a3/wd     : registered write into the file
//   pend                         : bits 1-14 vector entries, 15-20 scalar lanes
//   err                          : sticky illegal-destination flag
// ---------------------------------------------------------------------------
module rf_wb_arbiter
  import vec_pkg::wb_req_t;
  import vec_pkg::dst_legal;
  import vec_pkg::SCALAR_IDX;
  import vec_pkg::INVALID_IDX;
#(
  parameter int NREG  = 15,
  parameter int LANES = 6,
  parameter int W     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [3:0]                alu_dst,
  input  logic [LANES-1:0][W-1:0]   alu_data,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [3:0]                mem_dst,
  input  logic                      mem_scalar,
  input  logic [LANES-1:0][W-1:0]   mem_data,
  input  logic                      iss_valid,
  input  logic [3:0]                iss_dst,
  input  logic                      iss_scalar,
  input  logic [3:0]                chk_a1,
  input  logic [3:0]                chk_a2,
  input  logic                      chk_sflag,
  output logic                      stall,
  output logic                      rf_we,
  output logic                      rf_sflag,
  output logic                      rf_ldflag,
  output logic [3:0]                rf_a3,
  output logic [LANES-1:0][W-1:0]   rf_wd,
  output logic [NREG+LANES-1:0]     pend,
  output logic                      err
);

  localparam int PW = NREG + LANES;

  // One-hot scoreboard position of a destination. Scalar lanes live above
  // the vector entries so vector indices map straight onto bit positions.
  function automatic logic [PW-1:0] pend_bit(input logic [3:0] dst, input logic scalar);
    logic [PW-1:0] m;
    m = '0;
    for (int i = 0; i < PW; i++) begin
      if (scalar ? (i == NREG + int'(dst)) : (i == int'(dst))) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Is an index busy? Vector index 0 stands for the whole scalar bank;
  // index 15 and out-of-range scalar lanes are never tracked.
  function automatic logic idx_busy(input logic [3:0] idx, input logic scalar,
                                    input logic [PW-1:0] p);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (p[NREG+i] && (scalar ? (int'(idx) == i) : (idx == SCALAR_IDX))) hit = 1'b1;
    end
    if (!scalar && idx != SCALAR_IDX && idx != INVALID_IDX) begin
      for (int i = 1; i < NREG; i++) begin
        if (p[i] && int'(idx) == i) hit = 1'b1;
      end
    end
    return hit;
  endfunction

  logic    alu_gnt, mem_gnt;
  wb_req_t sel_req;
  logic    sel_valid, sel_mem, sel_legal;
  logic [PW-1:0] set_mask, clr_mask;

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req0 (alu_valid),
    .req1 (mem_valid),
    .gnt0 (alu_gnt),
    .gnt1 (mem_gnt)
  );

  assign alu_ready = alu_gnt;
  assign mem_ready = mem_gnt;

  // Steer the granted request into a common request record.
  always_comb begin
    sel_req   = '0;
    sel_mem   = 1'b0;
    sel_valid = alu_gnt | mem_gnt;
    if (mem_gnt) begin
      sel_req.dst    = mem_dst;
      sel_req.data   = mem_data;
      sel_req.scalar = mem_scalar;
      sel_mem        = 1'b1;
    end else if (alu_gnt) begin
      sel_req.dst    = alu_dst;
      sel_req.data   = alu_data;
      sel_req.scalar = 1'b0;
    end
    sel_legal = dst_legal(sel_req.dst, sel_req.scalar);
  end

  // Write stage. Illegal destinations are still consumed but never raise
  // the write enable; they latch err instead. The scalar flag doubles as
  // the record of whether the registered write targets a scalar lane.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we     <= 1'b0;
      rf_sflag  <= 1'b0;
      rf_ldflag <= 1'b0;
      rf_a3     <= '0;
      rf_wd     <= '0;
      err       <= 1'b0;
    end else begin
      rf_we <= sel_valid & sel_legal;
      if (sel_valid) begin
        rf_a3     <= sel_req.dst;
        rf_wd     <= sel_req.data;
        rf_sflag  <= sel_mem & sel_req.scalar;
        rf_ldflag <= sel_mem;
      end
      if (sel_valid && !sel_legal) err <= 1'b1;
    end
  end

  // Hazard check; the iss_dst term catches WAW against an older writer.
  always_comb begin
    stall = idx_busy(chk_a1, 1'b0, pend)
          | (chk_sflag ? (|pend[NREG +: LANES]) : idx_busy(chk_a2, 1'b0, pend))
          | idx_busy(iss_dst, iss_scalar, pend);
  end

  // Reservations only count when decode actually advances, and only for
  // destinations a write could ever clear.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_valid && !stall && dst_legal(iss_dst, iss_scalar))
      set_mask = pend_bit(iss_dst, iss_scalar);
    if (rf_we)
      clr_mask = pend_bit(rf_a3, rf_sflag);
  end

  // Set is applied after clear so a same-edge reservation survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~clr_mask) | set_mask;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_arbiter
// Directed bench for rf_wb_arbiter: arbitration order, write-stage flags,
// scoreboard set/clear, stall timing, illegal destinations and reset.
// ---------------------------------------------------------------------------
module tb_rf_wb_arbiter;

  logic             clk;
  logic             rst;
  logic             alu_valid, alu_ready;
  logic [3:0]       alu_dst;
  logic [5:0][7:0]  alu_data;
  logic             mem_valid, mem_ready;
  logic [3:0]       mem_dst;
  logic             mem_scalar;
  logic [5:0][7:0]  mem_data;
  logic             iss_valid;
  logic [3:0]       iss_dst;
  logic             iss_scalar;
  logic [3:0]       chk_a1, chk_a2;
  logic             chk_sflag;
  logic             stall;
  logic             rf_we, rf_sflag, rf_ldflag;
  logic [3:0]       rf_a3;
  logic [5:0][7:0]  rf_wd;
  logic [20:0]      pend;
  logic             err;

  int checks;
  int failures;

  rf_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_dst    (alu_dst),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_dst    (mem_dst),
    .mem_scalar (mem_scalar),
    .mem_data   (mem_data),
    .iss_valid  (iss_valid),
    .iss_dst    (iss_dst),
    .iss_scalar (iss_scalar),
    .chk_a1     (chk_a1),
    .chk_a2     (chk_a2),
    .chk_sflag  (chk_sflag),
    .stall      (stall),
    .rf_we      (rf_we),
    .rf_sflag   (rf_sflag),
    .rf_ldflag  (rf_ldflag),
    .rf_a3      (rf_a3),
    .rf_wd      (rf_wd),
    .pend       (pend),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge and let registered outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive both write-back requesters in one call.
  task automatic applyStimulus(input logic av, input logic [3:0] ad,
                               input logic mv, input logic [3:0] md,
                               input logic ms);
    alu_valid  = av;
    alu_dst    = ad;
    mem_valid  = mv;
    mem_dst    = md;
    mem_scalar = ms;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    alu_data   = 48'h060504030201;
    mem_data   = 48'h0;
    iss_valid  = 1'b0;
    iss_dst    = 4'd1;
    iss_scalar = 1'b0;
    chk_a1     = 4'd1;
    chk_a2     = 4'd1;
    chk_sflag  = 1'b0;
    applyStimulus(1'b1, 4'd2, 1'b1, 4'd5, 1'b0);
    tick();
    tick();

    // Reset state, with both requesters asserting
    checkOutput("rst_alu_ready", 64'(alu_ready), 64'd0);
    checkOutput("rst_mem_ready", 64'(mem_ready), 64'd0);
    checkOutput("rst_rf_we", 64'(rf_we), 64'd0);
    checkOutput("rst_flags", 64'({rf_sflag, rf_ldflag}), 64'd0);
    checkOutput("rst_a3", 64'(rf_a3), 64'd0);
    checkOutput("rst_wd", 64'(rf_wd), 64'd0);
    checkOutput("rst_pend", 64'(pend), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    checkOutput("rst_stall", 64'(stall), 64'd0);

    // Both requesters valid for three cycles: ALU, MEM, ALU
    rst = 1'b0;
    alu_data = 48'h222222222222;
    mem_data = 48'h555555555555;
    applyStimulus(1'b1, 4'd2, 1'b1, 4'd5, 1'b0);
    checkOutput("arb1_alu_ready", 64'(alu_ready), 64'd1);
    checkOutput("arb1_mem_ready", 64'(mem_ready), 64'd0);
    tick();
    checkOutput("arb1_rf_we", 64'(rf_we), 64'd1);
    checkOutput("arb1_a3", 64'(rf_a3), 64'd2);
    checkOutput("arb1_ldflag", 64'(rf_ldflag), 64'd0);
    checkOutput("arb2_mem_ready", 64'(mem_ready), 64'd1);
    checkOutput("arb2_alu_ready", 64'(alu_ready), 64'd0);
    tick();
    checkOutput("arb2_a3", 64'(rf_a3), 64'd5);
    checkOutput("arb2_ldflag", 64'(rf_ldflag), 64'd1);
    checkOutput("arb2_wd", 64'(rf_wd), 64'h555555555555);
    checkOutput("arb3_alu_ready", 64'(alu_ready), 64'd1);
    tick();
    applyStimulus(1'b0, 4'd2, 1'b0, 4'd5, 1'b0);
    checkOutput("arb3_a3", 64'(rf_a3), 64'd2);
    checkOutput("arb3_ldflag", 64'(rf_ldflag), 64'd0);
    tick();
    checkOutput("idle_rf_we", 64'(rf_we), 64'd0);

    // ALU only, dst 3, lanes 01..06 (MEM holds tie priority now)
    alu_data = 48'h060504030201;
    applyStimulus(1'b1, 4'd3, 1'b0, 4'd5, 1'b0);
    checkOutput("alu_ready_same_cycle", 64'(alu_ready), 64'd1);
    tick();
    applyStimulus(1'b0, 4'd3, 1'b0, 4'd5, 1'b0);
    checkOutput("alu_rf_we", 64'(rf_we), 64'd1);
    checkOutput("alu_a3", 64'(rf_a3), 64'd3);
    checkOutput("alu_wd", 64'(rf_wd), 64'h060504030201);
    checkOutput("alu_flags", 64'({rf_sflag, rf_ldflag}), 64'd0);
    tick();

    // Scalar load to lane 4 after reserving it
    iss_valid = 1'b1; iss_dst = 4'd4; iss_scalar = 1'b1;
    #1;
    checkOutput("iss_s4_stall", 64'(stall), 64'd0);
    tick();
    iss_valid = 1'b0; iss_dst = 4'd1; iss_scalar = 1'b0;
    chk_sflag = 1'b1;
    #1;
    checkOutput("s4_pend_set", 64'(pend), 64'h1 << 19);
    checkOutput("s4_sflag_stall", 64'(stall), 64'd1);
    chk_sflag = 1'b0; chk_a1 = 4'd0;
    #1;
    checkOutput("s4_idx0_stall", 64'(stall), 64'd1);
    chk_a1 = 4'd1;
    mem_data = 48'h0000000000AB;
    applyStimulus(1'b0, 4'd3, 1'b1, 4'd4, 1'b1);
    checkOutput("s4_mem_ready", 64'(mem_ready), 64'd1);
    tick();
    applyStimulus(1'b0, 4'd3, 1'b0, 4'd4, 1'b0);
    checkOutput("s4_rf_we", 64'(rf_we), 64'd1);
    checkOutput("s4_flags", 64'({rf_sflag, rf_ldflag}), 64'd3);
    checkOutput("s4_a3", 64'(rf_a3), 64'd4);
    checkOutput("s4_wd", 64'(rf_wd), 64'h0000000000AB);
    checkOutput("s4_pend_held", 64'(pend), 64'h1 << 19);
    tick();
    checkOutput("s4_pend_clear", 64'(pend), 64'd0);

    // RAW on entry 7; issues while stalled are ignored
    iss_valid = 1'b1; iss_dst = 4'd7;
    #1;
    checkOutput("r7_issue_stall", 64'(stall), 64'd0);
    tick();
    chk_a1 = 4'd7;
    #1;
    checkOutput("r7_stall", 64'(stall), 64'd1);
    iss_dst = 4'd11;
    tick();
    iss_valid = 1'b0; iss_dst = 4'd1;
    #1;
    checkOutput("r7_ignored_issue", 64'(pend), 64'h1 << 7);
    applyStimulus(1'b1, 4'd7, 1'b0, 4'd4, 1'b0);
    checkOutput("r7_stall_at_grant", 64'(stall), 64'd1);
    tick();
    applyStimulus(1'b0, 4'd7, 1'b0, 4'd4, 1'b0);
    checkOutput("r7_rf_we", 64'(rf_we), 64'd1);
    checkOutput("r7_stall_t1", 64'(stall), 64'd1);
    tick();
    checkOutput("r7_stall_t2", 64'(stall), 64'd0);
    checkOutput("r7_pend_clear", 64'(pend), 64'd0);
    chk_a1 = 4'd1;

    // Reservation of 9 on the same edge a write to 9 lands: set wins
    applyStimulus(1'b1, 4'd9, 1'b0, 4'd4, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd9, 1'b0, 4'd4, 1'b0);
    iss_valid = 1'b1; iss_dst = 4'd9;
    #1;
    checkOutput("p9_rf_we", 64'(rf_we), 64'd1);
    checkOutput("p9_no_stall", 64'(stall), 64'd0);
    tick();
    iss_valid = 1'b0; iss_dst = 4'd1;
    #1;
    checkOutput("p9_set_wins", 64'(pend), 64'h1 << 9);
    applyStimulus(1'b1, 4'd9, 1'b0, 4'd4, 1'b0);
    tick();
    applyStimulus(1'b0, 4'd9, 1'b0, 4'd4, 1'b0);
    tick();
    checkOutput("p9_clear", 64'(pend), 64'd0);

    // Illegal vector destination 15 on the load path
    applyStimulus(1'b0, 4'd9, 1'b1, 4'd15, 1'b0);
    checkOutput("ill_mem_ready", 64'(mem_ready), 64'd1);
    tick();
    applyStimulus(1'b0, 4'd9, 1'b0, 4'd15, 1'b0);
    checkOutput("ill_rf_we", 64'(rf_we), 64'd0);
    checkOutput("ill_err", 64'(err), 64'd1);
    tick();
    checkOutput("ill_err_sticky", 64'(err), 64'd1);

    // Reset while a registered write to 12 is in flight
    iss_valid = 1'b1; iss_dst = 4'd12;
    tick();
    iss_valid = 1'b0; iss_dst = 4'd1;
    applyStimulus(1'b1, 4'd12, 1'b0, 4'd4, 1'b0);
    checkOutput("r12_pend", 64'(pend), 64'h1 << 12);
    tick();
    applyStimulus(1'b0, 4'd12, 1'b0, 4'd4, 1'b0);
    checkOutput("r12_rf_we", 64'(rf_we), 64'd1);
    rst = 1'b1;
    applyStimulus(1'b1, 4'd3, 1'b1, 4'd5, 1'b0);
    checkOutput("r12_ready_in_rst", 64'({alu_ready, mem_ready}), 64'd0);
    tick();
    checkOutput("r12_rf_we_dropped", 64'(rf_we), 64'd0);
    checkOutput("r12_pend_cleared", 64'(pend), 64'd0);
    checkOutput("r12_err_cleared", 64'(err), 64'd0);
    rst = 1'b0;
    applyStimulus(1'b1, 4'd3, 1'b1, 4'd5, 1'b0);
    checkOutput("r12_prio_reset", 64'({alu_ready, mem_ready}), 64'b10);
    applyStimulus(1'b0, 4'd3, 1'b0, 4'd5, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
